// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI responder serial engine for all four CPOL/CPHA modes.
// Define SPI_SLAVE_STATUS_EN to add sticky rx_ovr/tx_udr flags.
module spi_slave_core #(
   parameter int CHAR_LEN    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                wb_clk_in,
   input  logic                wb_rst,
   input  logic                ss_pad_i,
   input  logic                sclk_pad_i,
   input  logic                mosi_pad_i,
   output logic                miso_pad_o,
   output logic                miso_oe_o,
   input  logic                cpol,
   input  logic                cpha,
   input  logic                lsb,
   input  logic [CHAR_LEN-1:0] tx_data,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic [CHAR_LEN-1:0] rx_data,
   output logic                rx_valid,
`ifdef SPI_SLAVE_STATUS_EN
   input  logic                rx_ack,
   input  logic                sts_clr,
   output logic                rx_ovr,
   output logic                tx_udr,
`endif
   output logic                busy
);

   localparam int CW = $clog2(CHAR_LEN);
   localparam logic [CW-1:0] LAST = CW'(CHAR_LEN - 1);

   typedef enum logic [1:0] {
      IDLE,
      SELECT,
      ACTIVE
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync, prm;
   logic ss_s, sclk_s, mosi_s;
   logic ss_d, sclk_d, armed;

   logic cpol_r, cpha_r, lsb_r;
   logic [CW-1:0] bit_cnt;
   logic [CHAR_LEN-1:0] rx_sr, rx_nxt;
   logic [CHAR_LEN-1:0] tx_sr, hold_q, load_word;
   logic hold_full;

   logic ss_fall, act;
   logic sclk_rise, sclk_fall, lead, trail;
   logic smp, shf, done, load, accept;
   logic ld_first, sr_first;
   logic [CHAR_LEN-1:0] ld_rest, sr_rest;

   assign ss_s   = ss_sync[SYNC_STAGES-1];
   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // armed blocks a still-low SS from looking like a fresh fall after reset
   always_ff @(posedge wb_clk_in or posedge wb_rst) begin
      if (wb_rst) begin
         ss_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         prm       <= '0;
         ss_d      <= 1'b1;
         sclk_d    <= 1'b0;
         armed     <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_pad_i};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pad_i};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pad_i};
         prm       <= {prm[SYNC_STAGES-2:0], 1'b1};
         ss_d      <= ss_s;
         sclk_d    <= sclk_s;
         armed     <= armed | (prm[SYNC_STAGES-1] & ss_s);
      end
   end

   assign ss_fall = armed & ss_d & ~ss_s;

   always_ff @(posedge wb_clk_in or posedge wb_rst) begin
      if (wb_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (ss_fall) state_d = SELECT;
         SELECT:  state_d = ACTIVE;
         ACTIVE:  state_d = ACTIVE;
         default: state_d = IDLE;
      endcase
      if (ss_s) state_d = IDLE;
   end

   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign lead      = cpol_r ? sclk_fall : sclk_rise;
   assign trail     = cpol_r ? sclk_rise : sclk_fall;
   assign act       = (state_q == ACTIVE) & ~ss_s;
   assign smp       = act & (cpha_r ? trail : lead);
   // cpha=0: the trailing edge right after a char boundary is not a shift
   assign shf       = act & (cpha_r ? lead : trail) &
                      (cpha_r | (bit_cnt != '0));
   assign done      = smp & (bit_cnt == LAST);
   assign load      = ~ss_s & ((state_q == SELECT) |
                      ((state_q == ACTIVE) & rx_valid));
   assign accept    = tx_valid & ~hold_full;
   assign load_word = hold_full ? hold_q : '0;

   assign rx_nxt   = lsb_r ? {mosi_s, rx_sr[CHAR_LEN-1:1]}
                           : {rx_sr[CHAR_LEN-2:0], mosi_s};
   assign ld_first = lsb_r ? load_word[0] : load_word[CHAR_LEN-1];
   assign ld_rest  = lsb_r ? (load_word >> 1) : (load_word << 1);
   assign sr_first = lsb_r ? tx_sr[0] : tx_sr[CHAR_LEN-1];
   assign sr_rest  = lsb_r ? (tx_sr >> 1) : (tx_sr << 1);

   always_ff @(posedge wb_clk_in or posedge wb_rst) begin
      if (wb_rst) begin
         cpol_r     <= 1'b0;
         cpha_r     <= 1'b0;
         lsb_r      <= 1'b0;
         bit_cnt    <= '0;
         rx_sr      <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         tx_sr      <= '0;
         miso_pad_o <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (state_q == IDLE) begin
            cpol_r <= cpol;
            cpha_r <= cpha;
            lsb_r  <= lsb;
         end
         if ((state_q == IDLE) || ss_s) begin
            bit_cnt    <= '0;
            miso_pad_o <= 1'b0;
         end else begin
            if (smp) begin
               rx_sr   <= rx_nxt;
               bit_cnt <= done ? '0 : bit_cnt + CW'(1);
            end
            if (done) begin
               rx_data  <= rx_nxt;
               rx_valid <= 1'b1;
            end
            if (load) begin
               tx_sr <= cpha_r ? load_word : ld_rest;
               if (!cpha_r) miso_pad_o <= ld_first;
            end else if (shf) begin
               miso_pad_o <= sr_first;
               tx_sr      <= sr_rest;
            end
         end
      end
   end

   always_ff @(posedge wb_clk_in or posedge wb_rst) begin
      if (wb_rst) begin
         hold_q    <= '0;
         hold_full <= 1'b0;
      end else if (accept) begin
         hold_q    <= tx_data;
         hold_full <= 1'b1;
      end else if (load) begin
         hold_full <= 1'b0;
      end
   end

`ifdef SPI_SLAVE_STATUS_EN
   logic unack;

   always_ff @(posedge wb_clk_in or posedge wb_rst) begin
      if (wb_rst) begin
         unack  <= 1'b0;
         rx_ovr <= 1'b0;
         tx_udr <= 1'b0;
      end else begin
         if (rx_valid) unack <= 1'b1;
         if (rx_ack)   unack <= 1'b0;
         if (sts_clr) begin
            rx_ovr <= 1'b0;
            tx_udr <= 1'b0;
         end else begin
            if (load & ~hold_full) tx_udr <= 1'b1;
            if (done & unack)      rx_ovr <= 1'b1;
         end
      end
   end
`endif

   assign tx_ready  = ~hold_full;
   assign miso_oe_o = (state_q != IDLE);
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: SPI master model with an rx scoreboard queue.
// Build with SPI_SLAVE_STATUS_EN defined to also cover the status flags.
module tb_spi_slave_core;

   localparam int H = 4;

   logic       wb_clk_in = 1'b0;
   logic       wb_rst = 1'b1;
   logic       ss_pad_i = 1'b1;
   logic       sclk_pad_i = 1'b0;
   logic       mosi_pad_i = 1'b0;
   logic       miso_pad_o, miso_oe_o;
   logic       cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
`ifdef SPI_SLAVE_STATUS_EN
   logic       rx_ack = 1'b1;
   logic       sts_clr = 1'b0;
   logic       rx_ovr, tx_udr;
`endif

   int n_run = 0;
   int n_fail = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mo[4];
   logic [7:0] mi[4];

   spi_slave_core #(.CHAR_LEN(8), .SYNC_STAGES(2)) dut (
      .wb_clk_in (wb_clk_in),
      .wb_rst    (wb_rst),
      .ss_pad_i  (ss_pad_i),
      .sclk_pad_i(sclk_pad_i),
      .mosi_pad_i(mosi_pad_i),
      .miso_pad_o(miso_pad_o),
      .miso_oe_o (miso_oe_o),
      .cpol      (cpol),
      .cpha      (cpha),
      .lsb       (lsb),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
`ifdef SPI_SLAVE_STATUS_EN
      .rx_ack    (rx_ack),
      .sts_clr   (sts_clr),
      .rx_ovr    (rx_ovr),
      .tx_udr    (tx_udr),
`endif
      .busy      (busy)
   );

   always #5 wb_clk_in = ~wb_clk_in;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   always @(negedge wb_clk_in) begin
      if (rx_valid) begin
         if (exp_q.size() == 0)
            check("rx_unexpected", 32'(rx_data), 32'h1_0000);
         else
            check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge wb_clk_in);
   endtask

   function automatic logic [2:0] bpos(input int k);
      return 3'(lsb ? (k % 8) : (7 - (k % 8)));
   endfunction

   task automatic set_mode(input logic p, input logic h, input logic l);
      cpol = p;
      sclk_pad_i = p;
      cpha = h;
      lsb = l;
      cyc(8);
   endtask

   task automatic push_tx(input logic [7:0] d);
      tx_data = d;
      tx_valid = 1'b1;
      cyc(1);
      tx_valid = 1'b0;
   endtask

   task automatic shift_bits(input int nb);
      for (int k = 0; k < nb; k++) begin
         if (k == 0 && !cpha) mosi_pad_i = mo[0][bpos(0)];
         cyc(H);
         sclk_pad_i = ~cpol;
         if (cpha) mosi_pad_i = mo[2'(k >> 3)][bpos(k)];
         else      mi[2'(k >> 3)][bpos(k)] = miso_pad_o;
         cyc(H);
         sclk_pad_i = cpol;
         if (cpha)
            mi[2'(k >> 3)][bpos(k)] = miso_pad_o;
         else if (k + 1 < nb)
            mosi_pad_i = mo[2'((k + 1) >> 3)][bpos(k + 1)];
      end
   endtask

   task automatic frame(input int nb);
      for (int i = 0; i < 4; i++) mi[i] = 8'hxx;
      ss_pad_i = 1'b0;
      cyc(8);
      shift_bits(nb);
      cyc(H);
      ss_pad_i = 1'b1;
      cyc(10);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_miso"}, 32'(miso_pad_o), 0);
      check({tag, "_oe"}, 32'(miso_oe_o), 0);
      check({tag, "_rdy"}, 32'(tx_ready), 1);
      check({tag, "_rxd"}, 32'(rx_data), 0);
      check({tag, "_rxv"}, 32'(rx_valid), 0);
      check({tag, "_busy"}, 32'(busy), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not end");
      $fatal(1);
   end

   initial begin
      cyc(3);
      check_reset_vals("rst");
      wb_rst = 1'b0;
      cyc(10);

      // Mode 0, MSB first
      set_mode(1'b0, 1'b0, 1'b0);
      push_tx(8'hA5);
      check("m0_rdy_full", 32'(tx_ready), 0);
      mo[0] = 8'h3C;
      exp_q.push_back(8'h3C);
      ss_pad_i = 1'b0;
      mosi_pad_i = mo[0][bpos(0)];
      cyc(8);
      check("m0_oe", 32'(miso_oe_o), 1);
      check("m0_busy", 32'(busy), 1);
      check("m0_rdy_sel", 32'(tx_ready), 1);
      shift_bits(8);
      cyc(H);
      ss_pad_i = 1'b1;
      cyc(10);
      check("m0_miso", 32'(mi[0]), 32'hA5);
      check("m0_q", 32'(exp_q.size()), 0);
      check("m0_oe_off", 32'(miso_oe_o), 0);

      // Mode 3, LSB first, two chars with a mid-frame handshake
      set_mode(1'b1, 1'b1, 1'b1);
      push_tx(8'h81);
      mo[0] = 8'h55;
      mo[1] = 8'hAA;
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      fork
         frame(16);
         begin
            int t = 0;
            while (!(busy && tx_ready) && t < 500) begin
               cyc(1);
               t++;
            end
            check("m3_rdy_wait", 32'(t < 500), 1);
            push_tx(8'h7E);
         end
      join
      check("m3_miso0", 32'(mi[0]), 32'h81);
      check("m3_miso1", 32'(mi[1]), 32'h7E);
      check("m3_q", 32'(exp_q.size()), 0);

      // Mode 1, underrun
      set_mode(1'b0, 1'b1, 1'b0);
      mo[0] = 8'hFF;
      exp_q.push_back(8'hFF);
      frame(8);
      check("m1_miso", 32'(mi[0]), 0);
      check("m1_rxd", 32'(rx_data), 32'hFF);
      check("m1_q", 32'(exp_q.size()), 0);
`ifdef SPI_SLAVE_STATUS_EN
      check("m1_udr", 32'(tx_udr), 1);
      check("m1_ovr", 32'(rx_ovr), 0);
      sts_clr = 1'b1;
      cyc(1);
      sts_clr = 1'b0;
      check("m1_udr_clr", 32'(tx_udr), 0);
`endif

      // SS raised after five SCLKs
      set_mode(1'b0, 1'b0, 1'b0);
      mo[0] = 8'h37;
      ss_pad_i = 1'b0;
      cyc(8);
      shift_bits(5);
      ss_pad_i = 1'b1;
      cyc(3);
      check("ab_oe", 32'(miso_oe_o), 0);
      check("ab_busy", 32'(busy), 0);
      cyc(10);
      check("ab_rxd", 32'(rx_data), 32'hFF);
      push_tx(8'h6B);
      mo[0] = 8'h12;
      exp_q.push_back(8'h12);
      frame(8);
      check("ab_miso", 32'(mi[0]), 32'h6B);
      check("ab_q", 32'(exp_q.size()), 0);

      // wb_rst mid-char with SS held low
      mo[0] = 8'h99;
      ss_pad_i = 1'b0;
      cyc(8);
      shift_bits(3);
      wb_rst = 1'b1;
      cyc(1);
      wb_rst = 1'b0;
      check_reset_vals("mr");
      mo[0] = 8'hFF;
      shift_bits(8);
      check("mr_busy", 32'(busy), 0);
      check("mr_oe", 32'(miso_oe_o), 0);
      ss_pad_i = 1'b1;
      cyc(10);
      push_tx(8'h3E);
      mo[0] = 8'hC3;
      exp_q.push_back(8'hC3);
      frame(8);
      check("mr_miso", 32'(mi[0]), 32'h3E);
      check("mr_rxd", 32'(rx_data), 32'hC3);
      check("mr_q", 32'(exp_q.size()), 0);

      // Mode 2, accept in the same cycle as the second char load
      set_mode(1'b1, 1'b0, 1'b0);
      check("m2_rdy", 32'(tx_ready), 1);
      mo[0] = 8'h11;
      mo[1] = 8'h22;
      mo[2] = 8'h33;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      fork
         frame(24);
         begin
            int t = 0;
            while (!rx_valid && t < 500) begin
               cyc(1);
               t++;
            end
            check("m2_rxv_wait", 32'(t < 500), 1);
            push_tx(8'h5A);
         end
      join
      check("m2_miso0", 32'(mi[0]), 0);
      check("m2_miso1", 32'(mi[1]), 0);
      check("m2_miso2", 32'(mi[2]), 32'h5A);
      check("m2_rdy_end", 32'(tx_ready), 1);
      check("m2_q", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
SPI slave (responder) serial engine, the far end of the SPI master's clock generator and shifter.
- Oversamples external SCLK, SS_n and MOSI in the wb_clk_in domain.
- Detects SCLK sample and shift edges for all four CPOL/CPHA modes.
- Assembles received characters and serialises transmit characters onto MISO.
- Sits between the SPI pads and the slave-side Wishbone register block: one TX holding register in, one RX strobe out.

Parameters:
CHAR_LEN, 8, bits per character (2..32)
SYNC_STAGES, 2, synchroniser flops on each pad input (>=2)

Ports:
wb_clk_in  in  1  system clock
wb_rst  in  1  reset
ss_pad_i  in  1  slave select, active low
sclk_pad_i  in  1  serial clock from master
mosi_pad_i  in  1  serial data from master
miso_pad_o  out  1  serial data to master
miso_oe_o  out  1  MISO output enable (high while selected)
cpol  in  1  SCLK idle level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
lsb  in  1  1: LSB first; 0: MSB first
tx_data  in  CHAR_LEN  next character to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  holding register empty
rx_data  out  CHAR_LEN  last complete received character
rx_valid  out  1  one-cycle strobe, rx_data updated
busy  out  1  frame in progress (synchronised SS asserted)

Behaviour:
- Reset is wb_rst, asynchronous, active-high; clock is wb_clk_in. Reset values: miso_pad_o=0, miso_oe_o=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0; bit counter=0; holding register empty; synchroniser flops=1 for SS and =cpol-independent 0 for SCLK and MOSI.
- Synchronisers: SYNC_STAGES flops per input, plus one history flop on SCLK and SS for edge detection.
- Leading edge: synced SCLK leaves its idle level, i.e. a rising edge when cpol=0. Trailing edge is the opposite transition.
- Sample edge = leading if cpha=0, trailing if cpha=1. Shift edge = the other edge.
- SCLK edges are ignored while synced SS is high.
- States:
  - IDLE: SS high.
  - SELECT: SS fell, 1 cycle.
  - ACTIVE.
- IDLE->SELECT on synced SS falling. SELECT->ACTIVE unconditionally. Any state->IDLE on synced SS high.
- Char load:
  - Occurs in SELECT and on the cycle after each CHAR_LEN-th sample.
  - The shift register takes the holding register and marks it empty.
  - If the holding register is empty, load all-zeros (underrun).
- MISO drive:
  - miso_oe_o=1 from SELECT until IDLE.
  - cpha=0: first bit is driven at load; subsequent bits advance on each shift edge.
  - cpha=1: the bit advances on each shift edge, including the first leading edge.
  - Bit order follows lsb.
- Sampling:
  - On each sample edge, MOSI (synced) shifts into the RX register in lsb order and the bit counter increments.
  - At count CHAR_LEN: rx_data updates, rx_valid pulses for exactly 1 cycle, and the counter wraps to 0.
  - The frame continues; back-to-back characters are supported without SS toggling.
- Latency: rx_valid asserts SYNC_STAGES+1 wb_clk_in cycles after the final sample edge at the pad. MISO changes SYNC_STAGES+1 cycles after a shift edge at the pad.
- Operating constraint: SCLK high and low phases are each >= SYNC_STAGES+2 wb_clk_in cycles.
- TX handshake:
  - tx_ready = holding register empty.
  - Transfer occurs when tx_valid && tx_ready.
  - Load and accept in the same cycle: the load sees empty and sends zeros; the accepted word fills the holding register for the next char.
- SS deasserted mid-character: the partial character is discarded, no rx_valid is issued, the counter clears, miso_oe_o=0, and the holding register is kept.
- wb_rst mid-frame: immediate return to reset values; an SS that is still asserted needs a fresh falling edge to start a new frame.
- cpol/cpha/lsb are sampled only in IDLE; changes during a frame take effect at the next frame.

Optional Feature:
SPI_SLAVE_STATUS_EN.
- Defined:
  - Adds outputs rx_ovr (1 bit), tx_udr (1 bit) and input sts_clr (1 bit).
  - tx_udr is set on a char load with the holding register empty.
  - rx_ovr is set when a new char completes while the previous rx_valid was not followed by any rx_ack pulse; in this build rx_ack is an added 1-bit input.
  - Both flags are sticky, cleared by sts_clr, reset 0. sts_clr has priority over set in the same cycle.
- Undefined: none of these ports exist and underrun/overrun go unreported.

Test Plan:
- Mode 0, lsb=0, wb_clk = 8x SCLK: tx_data=0xA5 preloaded, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1 on rising edges; rx_data=0x3C with a single rx_valid pulse; tx_ready=1 after SELECT.
- Mode 3, lsb=1: holding register loaded with 0x81 then 0x7E via handshake, two chars in one SS frame, master sends 0x55,0xAA -> master sees 0x81,0x7E; rx_valid twice with 0x55 then 0xAA.
- Mode 1, no tx_valid ever: master sends 0xFF -> MISO all 0; rx_data=0xFF; with SPI_SLAVE_STATUS_EN, tx_udr=1 until sts_clr.
- SS raised after 5 SCLK of a char -> no rx_valid, rx_data unchanged, miso_oe_o=0 within SYNC_STAGES+1 cycles; next frame receives 0x12 correctly.
- wb_rst pulsed mid-char with SS held low -> outputs at reset values; no activity until SS toggles; the following frame transfers 0xC3 correctly.
- Mode 2, tx_valid raised in the same cycle as the second char load with holding empty -> second char 0x00, third char carries the accepted word 0x5A.
